// File: rtl/mccpu_pkg.sv
// mccpu_pkg
// Shared definitions for the multi-cycle MIPS controller with variable-latency memory:
//   - FSM state encodings (3 bits, exposed on state_o)
//   - ALU operation codes driven on ALUOp
//   - Mux-select encodings for ALUSrcA/ALUSrcB/PCSource/GPRSel/WDSel
//   - Exception cause codes reported on exc_cause
//   - Opcode / funct constants
//   - decode_t, the instruction-class bundle produced by mccpu_decode
package mccpu_pkg;

  // FSM states
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [2:0] S_EXC = 3'd5;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_LUI  = 4'd9;

  // ALU operand A select
  localparam logic [2:0] ASRC_PC    = 3'd0;
  localparam logic [2:0] ASRC_RD1   = 3'd1;
  localparam logic [2:0] ASRC_SHAMT = 3'd2;
  localparam logic [2:0] ASRC_LUI   = 3'd3;
  localparam logic [2:0] ASRC_RD1V  = 3'd4;

  // ALU operand B select
  localparam logic [1:0] BSRC_RD2  = 2'd0;
  localparam logic [1:0] BSRC_FOUR = 2'd1;
  localparam logic [1:0] BSRC_IMM  = 2'd2;
  localparam logic [1:0] BSRC_BOFF = 2'd3;

  // Next-PC select
  localparam logic [2:0] PCS_ALU    = 3'd0;
  localparam logic [2:0] PCS_ALUOUT = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_RD1    = 3'd3;
  localparam logic [2:0] PCS_EXC    = 3'd4;

  // Register-file write address select
  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_RA = 2'd2;

  // Register-file write data select
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // Exception causes
  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ILLEGAL = 2'd1;
  localparam logic [1:0] EXC_IBUS    = 2'd2;
  localparam logic [1:0] EXC_DBUS    = 2'd3;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_JALR = 6'b001001;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  // Instruction class flags; at most one class flag is set for a legal
  // instruction. shift_imm/shift_var only steer ALU operand A.
  typedef struct packed {
    logic       shift_imm;  // sll, srl
    logic       shift_var;  // sllv, srlv
    logic       jr;
    logic       jalr;
    logic       j;
    logic       jal;
    logic       beq;
    logic       bne;
    logic       i_alu;      // addi, slti, andi, ori, lui
    logic       zext;       // andi, ori
    logic       lui;
    logic       lw;
    logic       sw;
    logic [3:0] alu_op;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/mccpu_decode.sv
// mccpu_decode
// Purely combinational instruction decoder for the multi-cycle controller.
// Ports:
//   op_i    in  6  IR[31:26]
//   funct_i in  6  IR[5:0]
//   dec_o   out    instruction-class flags, ALU operation and illegal flag
module mccpu_decode
  import mccpu_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output decode_t    dec_o
);

  always_comb begin
    dec_o        = '0;
    dec_o.alu_op = ALU_ADD;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          F_ADD, F_ADDU: dec_o.alu_op = ALU_ADD;
          F_SUB, F_SUBU: dec_o.alu_op = ALU_SUB;
          F_AND:         dec_o.alu_op = ALU_AND;
          F_OR:          dec_o.alu_op = ALU_OR;
          F_NOR:         dec_o.alu_op = ALU_NOR;
          F_SLT:         dec_o.alu_op = ALU_SLT;
          F_SLTU:        dec_o.alu_op = ALU_SLTU;
          F_SLL: begin
            dec_o.shift_imm = 1'b1;
            dec_o.alu_op    = ALU_SLL;
          end
          F_SRL: begin
            dec_o.shift_imm = 1'b1;
            dec_o.alu_op    = ALU_SRL;
          end
          F_SLLV: begin
            dec_o.shift_var = 1'b1;
            dec_o.alu_op    = ALU_SLL;
          end
          F_SRLV: begin
            dec_o.shift_var = 1'b1;
            dec_o.alu_op    = ALU_SRL;
          end
          F_JR:          dec_o.jr   = 1'b1;
          F_JALR:        dec_o.jalr = 1'b1;
          default:       dec_o.illegal = 1'b1;
        endcase
      end
      OP_J:   dec_o.j   = 1'b1;
      OP_JAL: dec_o.jal = 1'b1;
      OP_BEQ: begin
        dec_o.beq    = 1'b1;
        dec_o.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        dec_o.bne    = 1'b1;
        dec_o.alu_op = ALU_SUB;
      end
      OP_ADDI: dec_o.i_alu = 1'b1;
      OP_SLTI: begin
        dec_o.i_alu  = 1'b1;
        dec_o.alu_op = ALU_SLT;
      end
      OP_ANDI: begin
        dec_o.i_alu  = 1'b1;
        dec_o.zext   = 1'b1;
        dec_o.alu_op = ALU_AND;
      end
      OP_ORI: begin
        dec_o.i_alu  = 1'b1;
        dec_o.zext   = 1'b1;
        dec_o.alu_op = ALU_OR;
      end
      OP_LUI: begin
        dec_o.i_alu  = 1'b1;
        dec_o.lui    = 1'b1;
        dec_o.alu_op = ALU_LUI;
      end
      OP_LW:   dec_o.lw = 1'b1;
      OP_SW:   dec_o.sw = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mccpu_ctrl_ws.sv
// mccpu_ctrl_ws
// Multi-cycle MIPS control unit with a stalling memory port and precise
// exceptions. Holds the FSM, the memory wait counter and the cause register.
//
// Memory handshake: mem_req is high in IF and MEM and stays high until the
// cycle in which mem_ready is sampled high; that cycle completes the request.
// mem_ready is ignored while mem_req is low. A request still waiting when the
// counter reaches MEM_TIMEOUT-1 (and mem_ready is low) is a bus error.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   Zero                 ALU zero flag
//   Op, Funct            IR[31:26], IR[5:0]
//   mem_ready            memory completes the current request this cycle
//   mem_req              memory request
//   RegWrite, MemWrite, PCWrite, IRWrite, EPCWrite   write enables
//   EXTOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, GPRSel, WDSel, IorD   datapath selects
//   exc_valid            high during the EXC state
//   exc_cause            registered cause of the most recent exception
//   state_o              current FSM state (debug)
//
// MEM_TIMEOUT must be at least 2.
module mccpu_ctrl_ws
  import mccpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Zero,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       EPCWrite,
  output logic       EXTOp,
  output logic [2:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [2:0] PCSource,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       IorD,
  output logic       exc_valid,
  output logic [1:0] exc_cause,
  output logic [2:0] state_o
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  decode_t          dec;
  logic             wait_expired;

  mccpu_decode u_decode (
    .op_i    (Op),
    .funct_i (Funct),
    .dec_o   (dec)
  );

  // mem_ready has priority: expiry only counts when the memory is not done.
  assign wait_expired = !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Next state and all control outputs. While rst_n is low only the defaults
  // are driven, so no enable or request can pulse during reset.
  always_comb begin
    mem_req   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    EPCWrite  = 1'b0;
    EXTOp     = 1'b1;
    ALUSrcA   = ASRC_RD1;
    ALUSrcB   = BSRC_RD2;
    ALUOp     = ALU_ADD;
    PCSource  = PCS_ALU;
    GPRSel    = GPR_RD;
    WDSel     = WD_ALU;
    IorD      = 1'b0;
    exc_valid = 1'b0;
    state_d   = state_q;
    cause_d   = EXC_NONE;
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          mem_req = 1'b1;
          ALUSrcA = ASRC_PC;
          ALUSrcB = BSRC_FOUR;
          if (mem_ready) begin
            PCWrite = 1'b1;
            IRWrite = 1'b1;
            state_d = S_ID;
          end else if (wait_expired) begin
            state_d = S_EXC;
            cause_d = EXC_IBUS;
          end
        end

        S_ID: begin
          if (dec.illegal) begin
            state_d = S_EXC;
            cause_d = EXC_ILLEGAL;
          end else if (dec.j || dec.jal) begin
            PCSource = PCS_JUMP;
            PCWrite  = 1'b1;
            if (dec.jal) begin
              RegWrite = 1'b1;
              GPRSel   = GPR_RA;
              WDSel    = WD_PC;
            end
            state_d = S_IF;
          end else if (dec.jr || dec.jalr) begin
            PCSource = PCS_RD1;
            PCWrite  = 1'b1;
            if (dec.jalr) begin
              RegWrite = 1'b1;
              WDSel    = WD_PC;
            end
            state_d = S_IF;
          end else begin
            // Speculative branch target PC + offset, latched into ALUOut.
            ALUSrcA = ASRC_PC;
            ALUSrcB = BSRC_BOFF;
            state_d = S_EXE;
          end
        end

        S_EXE: begin
          ALUOp = dec.alu_op;
          if (dec.shift_imm)      ALUSrcA = ASRC_SHAMT;
          else if (dec.shift_var) ALUSrcA = ASRC_RD1V;
          else if (dec.lui)       ALUSrcA = ASRC_LUI;
          if (dec.i_alu || dec.lw || dec.sw) ALUSrcB = BSRC_IMM;
          if (dec.zext) EXTOp = 1'b0;
          if (dec.beq || dec.bne) begin
            PCSource = PCS_ALUOUT;
            PCWrite  = (dec.beq && Zero) || (dec.bne && !Zero);
            state_d  = S_IF;
          end else if (dec.lw || dec.sw) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end

        S_MEM: begin
          mem_req  = 1'b1;
          IorD     = 1'b1;
          MemWrite = dec.sw;
          if (mem_ready) begin
            state_d = dec.lw ? S_WB : S_IF;
          end else if (wait_expired) begin
            state_d = S_EXC;
            cause_d = EXC_DBUS;
          end
        end

        S_WB: begin
          RegWrite = 1'b1;
          if (dec.lw) WDSel = WD_MEM;
          if (dec.lw || dec.i_alu) GPRSel = GPR_RT;
          state_d = S_IF;
        end

        S_EXC: begin
          PCSource  = PCS_EXC;
          PCWrite   = 1'b1;
          EPCWrite  = 1'b1;
          exc_valid = 1'b1;
          state_d   = S_IF;
        end

        default: state_d = S_IF;
      endcase
    end
  end

  // Wait counter: restarts whenever a new request phase begins or a request
  // completes, and counts stalled request cycles otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && ((state_d == S_IF) || (state_d == S_MEM))) begin
      cnt_d = '0;
    end else if (mem_req) begin
      cnt_d = mem_ready ? '0 : (cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      cause_q <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Cause is captured only on entry to EXC and held until the next one.
      if ((state_d == S_EXC) && (state_q != S_EXC)) begin
        cause_q <= cause_d;
      end
    end
  end

  assign exc_cause = cause_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mccpu_ctrl_ws.sv
// tb_mccpu_ctrl_ws
// Directed bench for mccpu_ctrl_ws. Inputs are driven just after the falling
// edge and outputs are checked 1 time unit later, well away from the rising edge.
module tb_mccpu_ctrl_ws;
  import mccpu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       Zero;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       mem_req, RegWrite, MemWrite, PCWrite, IRWrite, EPCWrite, EXTOp, IorD, exc_valid;
  logic [2:0] ALUSrcA, PCSource, state_o;
  logic [1:0] ALUSrcB, GPRSel, WDSel, exc_cause;
  logic [3:0] ALUOp;

  int checks = 0;
  int errors = 0;

  mccpu_ctrl_ws #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .Zero(Zero), .Op(Op), .Funct(Funct),
    .mem_ready(mem_ready), .mem_req(mem_req), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .EPCWrite(EPCWrite), .EXTOp(EXTOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .GPRSel(GPRSel), .WDSel(WDSel),
    .IorD(IorD), .exc_valid(exc_valid), .exc_cause(exc_cause), .state_o(state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b1; Zero = 1'b0; Op = OP_ADDI; Funct = 6'd0;
    #1;
    checks++;
    if ({state_o, exc_cause} !== {S_IF, 2'd0}) begin
      errors++; $display("FAIL reset_state: got %b want %b", {state_o, exc_cause}, {S_IF, 2'd0});
    end
    checks++;
    if ({mem_req, RegWrite, MemWrite, PCWrite, IRWrite, EPCWrite, exc_valid} !== 7'b0) begin
      errors++; $display("FAIL reset_enables: got %b want 0000000",
                         {mem_req, RegWrite, MemWrite, PCWrite, IRWrite, EPCWrite, exc_valid});
    end
    checks++;
    if ({EXTOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, GPRSel, WDSel, IorD} !==
        {1'b1, 3'd1, 2'd0, ALU_ADD, 3'd0, 2'd0, 2'd0, 1'b0}) begin
      errors++; $display("FAIL reset_defaults: got %b want %b",
        {EXTOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, GPRSel, WDSel, IorD},
        {1'b1, 3'd1, 2'd0, ALU_ADD, 3'd0, 2'd0, 2'd0, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    checks++;
    if ({state_o, mem_req, PCWrite, ALUSrcA, ALUSrcB} !== {S_IF, 1'b1, 1'b0, 3'd0, 2'd1}) begin
      errors++; $display("FAIL reset_release_if: got %b want %b",
        {state_o, mem_req, PCWrite, ALUSrcA, ALUSrcB}, {S_IF, 1'b1, 1'b0, 3'd0, 2'd1});
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_addi;
    Op = OP_ADDI; Funct = 6'd0; mem_ready = 1'b1;
    #1;
    checks++;
    if ({state_o, mem_req, PCWrite, IRWrite} !== {S_IF, 3'b111}) begin
      errors++; $display("FAIL addi_if: got %b want %b", {state_o, mem_req, PCWrite, IRWrite}, {S_IF, 3'b111});
    end
    @(negedge clk); #1;
    checks++;
    if ({state_o, PCWrite, RegWrite, mem_req, ALUSrcA, ALUSrcB} !== {S_ID, 3'b000, 3'd0, 2'd3}) begin
      errors++; $display("FAIL addi_id: got %b want %b",
        {state_o, PCWrite, RegWrite, mem_req, ALUSrcA, ALUSrcB}, {S_ID, 3'b000, 3'd0, 2'd3});
    end
    @(negedge clk); #1;
    checks++;
    if ({state_o, ALUSrcA, ALUSrcB, ALUOp, EXTOp, RegWrite} !== {S_EXE, 3'd1, 2'd2, ALU_ADD, 1'b1, 1'b0}) begin
      errors++; $display("FAIL addi_exe: got %b want %b",
        {state_o, ALUSrcA, ALUSrcB, ALUOp, EXTOp, RegWrite}, {S_EXE, 3'd1, 2'd2, ALU_ADD, 1'b1, 1'b0});
    end
    @(negedge clk); #1;
    checks++;
    if ({state_o, RegWrite, GPRSel, WDSel} !== {S_WB, 1'b1, 2'd1, 2'd0}) begin
      errors++; $display("FAIL addi_wb: got %b want %b", {state_o, RegWrite, GPRSel, WDSel}, {S_WB, 1'b1, 2'd1, 2'd0});
    end
    @(negedge clk); #1;
    checks++;
    if (state_o !== S_IF) begin
      errors++; $display("FAIL addi_done: got %0d want %0d", state_o, S_IF);
    end
  endtask

  // ---------------------------------------------------------------------------
  // lw, 3 wait cycles on fetch and on data: 4 + 1 + 1 + 4 + 1 = 11 cycles.
  task automatic test_lw_wait;
    Op = OP_LW; Funct = 6'd0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      checks++;
      if ({state_o, mem_req, IRWrite, PCWrite} !== {S_IF, 1'b1, mem_ready, mem_ready}) begin
        errors++; $display("FAIL lw_fetch%0d: got %b want %b", i,
          {state_o, mem_req, IRWrite, PCWrite}, {S_IF, 1'b1, mem_ready, mem_ready});
      end
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    checks++;
    if (state_o !== S_ID) begin
      errors++; $display("FAIL lw_id: got %0d want %0d", state_o, S_ID);
    end
    @(negedge clk); #1;
    checks++;
    if ({state_o, ALUSrcB, ALUOp} !== {S_EXE, 2'd2, ALU_ADD}) begin
      errors++; $display("FAIL lw_exe: got %b want %b", {state_o, ALUSrcB, ALUOp}, {S_EXE, 2'd2, ALU_ADD});
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3); #1;
      checks++;
      if ({state_o, mem_req, IorD, MemWrite, RegWrite} !== {S_MEM, 4'b1100}) begin
        errors++; $display("FAIL lw_mem%0d: got %b want %b", i,
          {state_o, mem_req, IorD, MemWrite, RegWrite}, {S_MEM, 4'b1100});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({state_o, RegWrite, WDSel, GPRSel} !== {S_WB, 1'b1, 2'd1, 2'd1}) begin
      errors++; $display("FAIL lw_wb: got %b want %b", {state_o, RegWrite, WDSel, GPRSel}, {S_WB, 1'b1, 2'd1, 2'd1});
    end
    @(negedge clk); #1;
    checks++;
    if (state_o !== S_IF) begin
      errors++; $display("FAIL lw_done_11: got %0d want %0d", state_o, S_IF);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_branch;
    logic [5:0] op_t [4];
    logic       z_t  [4];
    logic       pw_t [4];
    op_t = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
    z_t  = '{1'b1, 1'b0, 1'b0, 1'b1};
    pw_t = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      Op = op_t[k]; Funct = 6'd0; Zero = z_t[k]; mem_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({state_o, PCWrite} !== {S_ID, 1'b0}) begin
        errors++; $display("FAIL br%0d_id: got %b want %b", k, {state_o, PCWrite}, {S_ID, 1'b0});
      end
      @(negedge clk); #1;
      checks++;
      if ({state_o, PCWrite, PCSource, ALUOp, ALUSrcB} !== {S_EXE, pw_t[k], 3'd1, ALU_SUB, 2'd0}) begin
        errors++; $display("FAIL br%0d_exe: got %b want %b", k,
          {state_o, PCWrite, PCSource, ALUOp, ALUSrcB}, {S_EXE, pw_t[k], 3'd1, ALU_SUB, 2'd0});
      end
      @(negedge clk); #1;
      checks++;
      if (state_o !== S_IF) begin
        errors++; $display("FAIL br%0d_done: got %0d want %0d", k, state_o, S_IF);
      end
    end
    Zero = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_jumps;
    logic [5:0] op_t [4];
    logic [5:0] fn_t [4];
    logic [7:0] exp_t [4];  // {PCSource, RegWrite, GPRSel, WDSel}
    op_t  = '{OP_J, OP_JAL, OP_RTYPE, OP_RTYPE};
    fn_t  = '{6'd0, 6'd0, F_JR, F_JALR};
    exp_t = '{{3'd2, 1'b0, 2'd0, 2'd0}, {3'd2, 1'b1, 2'd2, 2'd2},
              {3'd3, 1'b0, 2'd0, 2'd0}, {3'd3, 1'b1, 2'd0, 2'd2}};
    for (int k = 0; k < 4; k++) begin
      Op = op_t[k]; Funct = fn_t[k]; mem_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({state_o, PCWrite, PCSource, RegWrite, GPRSel, WDSel} !== {S_ID, 1'b1, exp_t[k]}) begin
        errors++; $display("FAIL jmp%0d_id: got %b want %b", k,
          {state_o, PCWrite, PCSource, RegWrite, GPRSel, WDSel}, {S_ID, 1'b1, exp_t[k]});
      end
      @(negedge clk); #1;
      checks++;
      if (state_o !== S_IF) begin
        errors++; $display("FAIL jmp%0d_done: got %0d want %0d", k, state_o, S_IF);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_alu_forms;
    logic [5:0]  op_t [6];
    logic [5:0]  fn_t [6];
    logic [10:0] exe_t [6];  // {ALUSrcA, ALUSrcB, ALUOp, EXTOp, GPRSel[0]}
    op_t  = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ORI, OP_ANDI, OP_LUI};
    fn_t  = '{F_SLLV, F_SLL, F_SUB, 6'd0, 6'd0, 6'd0};
    exe_t = '{{3'd4, 2'd0, ALU_SLL, 1'b1, 1'b0}, {3'd2, 2'd0, ALU_SLL, 1'b1, 1'b0},
              {3'd1, 2'd0, ALU_SUB, 1'b1, 1'b0}, {3'd1, 2'd2, ALU_OR,  1'b0, 1'b1},
              {3'd1, 2'd2, ALU_AND, 1'b0, 1'b1}, {3'd3, 2'd2, ALU_LUI, 1'b1, 1'b1}};
    for (int k = 0; k < 6; k++) begin
      Op = op_t[k]; Funct = fn_t[k]; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if ({state_o, ALUSrcA, ALUSrcB, ALUOp, EXTOp} !== {S_EXE, exe_t[k][10:1]}) begin
        errors++; $display("FAIL alu%0d_exe: got %b want %b", k,
          {state_o, ALUSrcA, ALUSrcB, ALUOp, EXTOp}, {S_EXE, exe_t[k][10:1]});
      end
      @(negedge clk); #1;
      checks++;
      if ({state_o, RegWrite, GPRSel, WDSel} !== {S_WB, 1'b1, 1'b0, exe_t[k][0], 2'd0}) begin
        errors++; $display("FAIL alu%0d_wb: got %b want %b", k,
          {state_o, RegWrite, GPRSel, WDSel}, {S_WB, 1'b1, 1'b0, exe_t[k][0], 2'd0});
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_illegal;
    logic [5:0] op_t [2];
    logic [5:0] fn_t [2];
    op_t = '{6'b111111, OP_RTYPE};
    fn_t = '{6'd0, 6'b000001};
    for (int k = 0; k < 2; k++) begin
      Op = op_t[k]; Funct = fn_t[k]; mem_ready = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({state_o, PCWrite, RegWrite, EPCWrite} !== {S_ID, 3'b000}) begin
        errors++; $display("FAIL ill%0d_id: got %b want %b", k, {state_o, PCWrite, RegWrite, EPCWrite}, {S_ID, 3'b000});
      end
      @(negedge clk); #1;
      checks++;
      if ({state_o, PCSource, PCWrite, EPCWrite, exc_valid, exc_cause} !== {S_EXC, 3'd4, 3'b111, 2'd1}) begin
        errors++; $display("FAIL ill%0d_exc: got %b want %b", k,
          {state_o, PCSource, PCWrite, EPCWrite, exc_valid, exc_cause}, {S_EXC, 3'd4, 3'b111, 2'd1});
      end
      @(negedge clk); #1;
      checks++;
      if ({state_o, EPCWrite, exc_valid, exc_cause} !== {S_IF, 2'b00, 2'd1}) begin
        errors++; $display("FAIL ill%0d_after: got %b want %b", k,
          {state_o, EPCWrite, exc_valid, exc_cause}, {S_IF, 2'b00, 2'd1});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fetch_timeout;
    Op = OP_ADDI; Funct = 6'd0; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if ({state_o, mem_req, PCWrite, IRWrite} !== {S_IF, 3'b100}) begin
        errors++; $display("FAIL ifto_wait%0d: got %b want %b", i, {state_o, mem_req, PCWrite, IRWrite}, {S_IF, 3'b100});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({state_o, exc_cause, EPCWrite, mem_req} !== {S_EXC, 2'd2, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ifto_exc: got %b want %b", {state_o, exc_cause, EPCWrite, mem_req}, {S_EXC, 2'd2, 1'b1, 1'b0});
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Store that never completes, then one whose ready arrives on the last cycle.
  task automatic test_sw_timeout;
    for (int pass = 0; pass < 2; pass++) begin
      Op = OP_SW; Funct = 6'd0; mem_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      checks++;
      if ({state_o, ALUSrcB, MemWrite} !== {S_EXE, 2'd2, 1'b0}) begin
        errors++; $display("FAIL sw%0d_exe: got %b want %b", pass, {state_o, ALUSrcB, MemWrite}, {S_EXE, 2'd2, 1'b0});
      end
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        mem_ready = (pass == 1) && (i == 15); #1;
        checks++;
        if ({state_o, MemWrite, mem_req, IorD} !== {S_MEM, 3'b111}) begin
          errors++; $display("FAIL sw%0d_mem%0d: got %b want %b", pass, i,
            {state_o, MemWrite, mem_req, IorD}, {S_MEM, 3'b111});
        end
        @(negedge clk);
      end
      mem_ready = 1'b1; #1;
      if (pass == 0) begin
        checks++;
        if ({state_o, MemWrite, exc_cause, PCSource} !== {S_EXC, 1'b0, 2'd3, 3'd4}) begin
          errors++; $display("FAIL sw_timeout_exc: got %b want %b",
            {state_o, MemWrite, exc_cause, PCSource}, {S_EXC, 1'b0, 2'd3, 3'd4});
        end
        @(negedge clk);
      end else begin
        checks++;
        if ({state_o, MemWrite, EPCWrite, exc_cause} !== {S_IF, 2'b00, 2'd3}) begin
          errors++; $display("FAIL sw_late_ready: got %b want %b",
            {state_o, MemWrite, EPCWrite, exc_cause}, {S_IF, 2'b00, 2'd3});
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid;
    Op = OP_LW; Funct = 6'd0; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    mem_ready = 1'b0; #1;
    checks++;
    if ({state_o, mem_req} !== {S_MEM, 1'b1}) begin
      errors++; $display("FAIL rstmid_mem: got %b want %b", {state_o, mem_req}, {S_MEM, 1'b1});
    end
    #1 rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if ({state_o, mem_req, RegWrite, MemWrite, PCWrite, IRWrite, EPCWrite, exc_valid, IorD} !==
        {S_IF, 8'b0}) begin
      errors++; $display("FAIL rstmid_async: got %b want %b",
        {state_o, mem_req, RegWrite, MemWrite, PCWrite, IRWrite, EPCWrite, exc_valid, IorD}, {S_IF, 8'b0});
    end
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0; #1;
    checks++;
    if ({state_o, mem_req, exc_cause} !== {S_IF, 1'b1, 2'd0}) begin
      errors++; $display("FAIL rstmid_release: got %b want %b", {state_o, mem_req, exc_cause}, {S_IF, 1'b1, 2'd0});
    end
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_alu_forms();
    test_illegal();
    test_fetch_timeout();
    test_sw_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
